vreq_issue: RTL and testbench

- Instruction-side initiator feeding the vector add/min/max ALU request stream.
- Accepts one decoded vector-arithmetic instruction (vl, sew, opSel, source/destination register word addresses) and reads both source operands from the vector register file one data word per cycle.
- Drives the ALU request interface: operands, destination address, byte enables, mask start index, and start/end markers.
- No backpressure from the ALU; issue rate is fixed at one word per cycle.

---
 rtl/vreq_issue.sv | 204 ++++++++++++++++++++
 tb/tb_vreq_issue.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vreq_issue.sv
// vreq_issue: takes one decoded vector add/min/max instruction, reads both
// source operands from the register file one word per cycle, and forwards
// each word to the ALU together with its byte enables, destination address
// and mask bit offset.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for an instruction; instr_ready high
// S_ISSUE | one register-file read per cycle, k = 0 .. words-1
// S_DRAIN | last read returned; present the final ALU beat
module vreq_issue #(
  parameter int REQ_DATA_WIDTH    = 64,
  parameter int REQ_BYTE_EN_WIDTH = REQ_DATA_WIDTH/8,
  parameter int REQ_ADDR_WIDTH    = 32,
  parameter int SEW_WIDTH         = 2,
  parameter int OPSEL_WIDTH       = 9,
  parameter int VL_WIDTH          = 11,
  parameter int ENABLE_64_BIT     = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         instr_valid,
  output logic                         instr_ready,
  input  logic [VL_WIDTH-1:0]          instr_vl,
  input  logic [SEW_WIDTH-1:0]         instr_sew,
  input  logic [OPSEL_WIDTH-1:0]       instr_opSel,
  input  logic                         instr_carry,
  input  logic                         instr_mask,
  input  logic                         instr_avg,
  input  logic [REQ_ADDR_WIDTH-1:0]    instr_vs1,
  input  logic [REQ_ADDR_WIDTH-1:0]    instr_vs2,
  input  logic [REQ_ADDR_WIDTH-1:0]    instr_vd,
  output logic                         rf_rd_en,
  output logic [REQ_ADDR_WIDTH-1:0]    rf_rd_addr0,
  output logic [REQ_ADDR_WIDTH-1:0]    rf_rd_addr1,
  input  logic [REQ_DATA_WIDTH-1:0]    rf_rd_data0,
  input  logic [REQ_DATA_WIDTH-1:0]    rf_rd_data1,
  output logic                         alu_valid,
  output logic [REQ_DATA_WIDTH-1:0]    alu_vec0,
  output logic [REQ_DATA_WIDTH-1:0]    alu_vec1,
  output logic [SEW_WIDTH-1:0]         alu_sew,
  output logic [OPSEL_WIDTH-1:0]       alu_opSel,
  output logic                         alu_carry,
  output logic                         alu_mask,
  output logic                         alu_avg,
  output logic [REQ_ADDR_WIDTH-1:0]    alu_addr,
  output logic [REQ_BYTE_EN_WIDTH-1:0] alu_be,
  output logic [5:0]                   alu_start_idx,
  output logic                         alu_req_start,
  output logic                         alu_req_end,
  output logic                         done,
  output logic                         err
);

  localparam int LOG2B = $clog2(REQ_BYTE_EN_WIDTH);
  localparam int LOG2D = $clog2(REQ_DATA_WIDTH);
  localparam int VW1   = VL_WIDTH + 1;
  localparam logic [REQ_BYTE_EN_WIDTH-1:0] BE_ONE = REQ_BYTE_EN_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t r_state, w_next;

  logic [VL_WIDTH-1:0]       r_vl, r_k, r_last;
  logic [SEW_WIDTH-1:0]      r_sew;
  logic [2:0]                r_lb;
  logic [OPSEL_WIDTH-1:0]    r_opsel;
  logic                      r_carry, r_mask, r_avg;
  logic [REQ_ADDR_WIDTH-1:0] r_vs1, r_vs2, r_vd;

  logic                         r_alu_valid, r_req_start, r_req_end, r_done, r_err;
  logic [REQ_ADDR_WIDTH-1:0]    r_alu_addr;
  logic [REQ_BYTE_EN_WIDTH-1:0] r_alu_be;
  logic [5:0]                   r_start_idx;

  // Accept-time decode: log2(elements per word) and the word count.
  logic                w_accept, w_sew_bad, w_vl_zero;
  logic [2:0]          w_lb_in;
  logic [VL_WIDTH:0]   w_round;
  logic [VL_WIDTH-1:0] w_words_in;

  assign w_accept   = instr_valid && (r_state == S_IDLE);
  assign w_sew_bad  = (instr_sew == SEW_WIDTH'(3)) && (ENABLE_64_BIT == 0);
  assign w_vl_zero  = (instr_vl == '0);
  assign w_lb_in    = 3'(LOG2B) - 3'(instr_sew);
  assign w_round    = {1'b0, instr_vl} + (VW1'(1) << w_lb_in) - VW1'(1);
  assign w_words_in = VL_WIDTH'(w_round >> w_lb_in);

  // Per-word values for the word currently being read (k = r_k).
  logic [VL_WIDTH-1:0] w_elem, w_rem, w_epw, w_nbytes;
  logic                w_full, w_last_k;

  assign w_elem   = r_k << r_lb;
  assign w_rem    = r_vl - w_elem;
  assign w_epw    = VL_WIDTH'(1) << r_lb;
  assign w_full   = (w_rem >= w_epw);
  assign w_nbytes = w_rem << r_sew;
  assign w_last_k = (r_k == r_last);

  assign instr_ready = (r_state == S_IDLE);
  assign rf_rd_en    = (r_state == S_ISSUE);
  assign rf_rd_addr0 = rf_rd_en ? r_vs1 + REQ_ADDR_WIDTH'(r_k) : '0;
  assign rf_rd_addr1 = rf_rd_en ? r_vs2 + REQ_ADDR_WIDTH'(r_k) : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state: zero-length and illegal-sew instructions never leave IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && !w_sew_bad && !w_vl_zero) w_next = S_ISSUE;
      S_ISSUE: if (w_last_k) w_next = S_DRAIN;
      S_DRAIN: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Latch instruction fields on accept; advance the word counter while issuing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vl <= '0; r_k <= '0; r_last <= '0; r_sew <= '0; r_lb <= '0;
      r_opsel <= '0; r_carry <= 1'b0; r_mask <= 1'b0; r_avg <= 1'b0;
      r_vs1 <= '0; r_vs2 <= '0; r_vd <= '0;
    end else if (w_accept) begin
      r_vl    <= instr_vl;
      r_k     <= '0;
      r_last  <= w_words_in - VL_WIDTH'(1);
      r_sew   <= instr_sew;
      r_lb    <= w_lb_in;
      r_opsel <= instr_opSel;
      r_carry <= instr_carry;
      r_mask  <= instr_mask;
      r_avg   <= instr_avg;
      r_vs1   <= instr_vs1;
      r_vs2   <= instr_vs2;
      r_vd    <= instr_vd;
    end else if (r_state == S_ISSUE) begin
      r_k <= r_k + VL_WIDTH'(1);
    end
  end

  // Register per-word metadata alongside the read so it lines up with the returned data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_valid <= 1'b0; r_req_start <= 1'b0; r_req_end <= 1'b0;
      r_alu_addr <= '0; r_alu_be <= '0; r_start_idx <= '0;
      r_done <= 1'b0; r_err <= 1'b0;
    end else begin
      r_alu_valid <= (r_state == S_ISSUE);
      r_req_start <= (r_k == '0);
      r_req_end   <= w_last_k;
      r_alu_be    <= w_full ? '1 : (BE_ONE << w_nbytes) - BE_ONE;
      if (r_opsel[OPSEL_WIDTH-1]) begin
        r_alu_addr  <= r_vd + REQ_ADDR_WIDTH'(w_elem >> LOG2D);
        r_start_idx <= 6'(w_elem & VL_WIDTH'(REQ_DATA_WIDTH-1));
      end else begin
        r_alu_addr  <= r_vd + REQ_ADDR_WIDTH'(r_k);
        r_start_idx <= '0;
      end
      r_done <= (w_accept && !w_sew_bad && w_vl_zero) ||
                ((r_state == S_ISSUE) && w_last_k);
      r_err  <= w_accept && w_sew_bad;
    end
  end

  // ALU request outputs, forced to zero outside a valid beat.
  always_comb begin
    alu_valid     = r_alu_valid;
    alu_vec0      = '0;
    alu_vec1      = '0;
    alu_sew       = '0;
    alu_opSel     = '0;
    alu_carry     = 1'b0;
    alu_mask      = 1'b0;
    alu_avg       = 1'b0;
    alu_addr      = '0;
    alu_be        = '0;
    alu_start_idx = '0;
    alu_req_start = 1'b0;
    alu_req_end   = 1'b0;
    if (r_alu_valid) begin
      alu_vec0      = rf_rd_data0;
      alu_vec1      = rf_rd_data1;
      alu_sew       = r_sew;
      alu_opSel     = r_opsel;
      alu_carry     = r_carry;
      alu_mask      = r_mask;
      alu_avg       = r_avg;
      alu_addr      = r_alu_addr;
      alu_be        = r_alu_be;
      alu_start_idx = r_start_idx;
      alu_req_start = r_req_start;
      alu_req_end   = r_req_end;
    end
  end

  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_vreq_issue.sv
// Directed bench for vreq_issue: a default instance (sew=3 illegal) and a
// 64-bit-enabled instance share stimulus; each has its own register-file model.
module tb_vreq_issue;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        instr_valid;
  logic [10:0] instr_vl;
  logic [1:0]  instr_sew;
  logic [8:0]  instr_opSel;
  logic        instr_carry, instr_mask, instr_avg;
  logic [31:0] instr_vs1, instr_vs2, instr_vd;

  logic        instr_ready, rf_rd_en, alu_valid, alu_carry, alu_mask, alu_avg;
  logic        alu_req_start, alu_req_end, done, err;
  logic [31:0] rf_rd_addr0, rf_rd_addr1, alu_addr;
  logic [63:0] rf_rd_data0, rf_rd_data1, alu_vec0, alu_vec1;
  logic [1:0]  alu_sew;
  logic [8:0]  alu_opSel;
  logic [7:0]  alu_be;
  logic [5:0]  alu_start_idx;

  logic        x_instr_ready, x_rf_rd_en, x_alu_valid, x_alu_carry, x_alu_mask, x_alu_avg;
  logic        x_alu_req_start, x_alu_req_end, x_done, x_err;
  logic [31:0] x_rf_rd_addr0, x_rf_rd_addr1, x_alu_addr;
  logic [63:0] x_rf_rd_data0, x_rf_rd_data1, x_alu_vec0, x_alu_vec1;
  logic [1:0]  x_alu_sew;
  logic [8:0]  x_alu_opSel;
  logic [7:0]  x_alu_be;
  logic [5:0]  x_alu_start_idx;

  vreq_issue dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_vl(instr_vl), .instr_sew(instr_sew), .instr_opSel(instr_opSel),
    .instr_carry(instr_carry), .instr_mask(instr_mask), .instr_avg(instr_avg),
    .instr_vs1(instr_vs1), .instr_vs2(instr_vs2), .instr_vd(instr_vd),
    .rf_rd_en(rf_rd_en), .rf_rd_addr0(rf_rd_addr0), .rf_rd_addr1(rf_rd_addr1),
    .rf_rd_data0(rf_rd_data0), .rf_rd_data1(rf_rd_data1),
    .alu_valid(alu_valid), .alu_vec0(alu_vec0), .alu_vec1(alu_vec1),
    .alu_sew(alu_sew), .alu_opSel(alu_opSel), .alu_carry(alu_carry),
    .alu_mask(alu_mask), .alu_avg(alu_avg), .alu_addr(alu_addr), .alu_be(alu_be),
    .alu_start_idx(alu_start_idx), .alu_req_start(alu_req_start),
    .alu_req_end(alu_req_end), .done(done), .err(err)
  );

  vreq_issue #(.ENABLE_64_BIT(1)) dut64 (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(x_instr_ready),
    .instr_vl(instr_vl), .instr_sew(instr_sew), .instr_opSel(instr_opSel),
    .instr_carry(instr_carry), .instr_mask(instr_mask), .instr_avg(instr_avg),
    .instr_vs1(instr_vs1), .instr_vs2(instr_vs2), .instr_vd(instr_vd),
    .rf_rd_en(x_rf_rd_en), .rf_rd_addr0(x_rf_rd_addr0), .rf_rd_addr1(x_rf_rd_addr1),
    .rf_rd_data0(x_rf_rd_data0), .rf_rd_data1(x_rf_rd_data1),
    .alu_valid(x_alu_valid), .alu_vec0(x_alu_vec0), .alu_vec1(x_alu_vec1),
    .alu_sew(x_alu_sew), .alu_opSel(x_alu_opSel), .alu_carry(x_alu_carry),
    .alu_mask(x_alu_mask), .alu_avg(x_alu_avg), .alu_addr(x_alu_addr), .alu_be(x_alu_be),
    .alu_start_idx(x_alu_start_idx), .alu_req_start(x_alu_req_start),
    .alu_req_end(x_alu_req_end), .done(x_done), .err(x_err)
  );

  // Register-file models: data returns one cycle after the read strobe.
  always @(posedge clk) begin
    rf_rd_data0   <= rf_rd_en   ? {32'h0A0A0A0A, rf_rd_addr0}   : 64'h0;
    rf_rd_data1   <= rf_rd_en   ? {32'h0B0B0B0B, rf_rd_addr1}   : 64'h0;
    x_rf_rd_data0 <= x_rf_rd_en ? {32'h0A0A0A0A, x_rf_rd_addr0} : 64'h0;
    x_rf_rd_data1 <= x_rf_rd_en ? {32'h0B0B0B0B, x_rf_rd_addr1} : 64'h0;
  end

  int tests = 0;
  int fails = 0;

  // Per-cycle capture; index c = cycles after the accept edge.
  logic        q_ready[40], q_rden[40], q_val[40], q_st[40], q_en[40], q_done[40], q_err[40];
  logic [31:0] q_a0[40], q_a1[40], q_addr[40];
  logic [7:0]  q_be[40];
  logic [5:0]  q_sidx[40];
  logic [63:0] q_v0[40], q_v1[40];
  logic        x_val[40], x_dn[40];
  logic [7:0]  x_be[40];
  logic [63:0] x_v0[40];

  task automatic issue(input logic [10:0] vl, input logic [1:0] sew, input logic [8:0] op,
                       input logic [31:0] vs1, input logic [31:0] vs2, input logic [31:0] vd,
                       input int hold, input int ncyc);
    @(negedge clk);
    instr_vl = vl; instr_sew = sew; instr_opSel = op;
    instr_vs1 = vs1; instr_vs2 = vs2; instr_vd = vd;
    instr_carry = 1'b1; instr_mask = 1'b0; instr_avg = 1'b1;
    instr_valid = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      q_ready[c] = instr_ready; q_rden[c] = rf_rd_en; q_val[c] = alu_valid;
      q_st[c] = alu_req_start; q_en[c] = alu_req_end; q_done[c] = done; q_err[c] = err;
      q_a0[c] = rf_rd_addr0; q_a1[c] = rf_rd_addr1; q_addr[c] = alu_addr;
      q_be[c] = alu_be; q_sidx[c] = alu_start_idx; q_v0[c] = alu_vec0; q_v1[c] = alu_vec1;
      x_val[c] = x_alu_valid; x_dn[c] = x_done; x_be[c] = x_alu_be; x_v0[c] = x_alu_vec0;
      if (c == 1) instr_vd = 32'h99;
      if (c >= hold) instr_valid = 1'b0;
    end
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b0;
    instr_vl = '0; instr_sew = '0; instr_opSel = '0; instr_carry = 1'b0;
    instr_mask = 1'b0; instr_avg = 1'b0; instr_vs1 = '0; instr_vs2 = '0; instr_vd = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({instr_ready, rf_rd_en, alu_valid, done, err, alu_req_start, alu_req_end} !== 7'b1000000) begin
      fails++; $display("FAIL reset_ctl got %b want 1000000",
        {instr_ready, rf_rd_en, alu_valid, done, err, alu_req_start, alu_req_end});
    end
    tests++;
    if ({rf_rd_addr0, alu_addr, alu_be, alu_vec0} !== '0) begin
      fails++; $display("FAIL reset_data got a0=%h addr=%h be=%h v0=%h want 0",
        rf_rd_addr0, alu_addr, alu_be, alu_vec0);
    end
    rst = 1'b0;
  endtask

  // sew=0 vl=20, with instr_valid held (and vd changed) while busy
  task automatic test_basic_busy();
    logic [7:0] be_exp[3];
    be_exp[0] = 8'hFF; be_exp[1] = 8'hFF; be_exp[2] = 8'h0F;
    issue(11'd20, 2'd0, 9'h000, 32'h10, 32'h20, 32'h30, 4, 6);
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (q_rden[1+k] !== 1'b1 || q_a0[1+k] !== 32'h10 + k || q_a1[1+k] !== 32'h20 + k) begin
        fails++; $display("FAIL basic_read k=%0d got en=%b a0=%h a1=%h", k, q_rden[1+k], q_a0[1+k], q_a1[1+k]);
      end
      tests++;
      if (q_val[2+k] !== 1'b1 || q_addr[2+k] !== 32'h30 + k || q_be[2+k] !== be_exp[k]) begin
        fails++; $display("FAIL basic_beat k=%0d got v=%b addr=%h be=%h want be=%h",
          k, q_val[2+k], q_addr[2+k], q_be[2+k], be_exp[k]);
      end
      tests++;
      if (q_st[2+k] !== (k == 0) || q_en[2+k] !== (k == 2) || q_done[2+k] !== (k == 2)) begin
        fails++; $display("FAIL basic_markers k=%0d got st=%b en=%b done=%b", k, q_st[2+k], q_en[2+k], q_done[2+k]);
      end
      tests++;
      if (q_v0[2+k] !== {32'h0A0A0A0A, 32'h10 + k} || q_v1[2+k] !== {32'h0B0B0B0B, 32'h20 + k}) begin
        fails++; $display("FAIL basic_data k=%0d got v0=%h v1=%h", k, q_v0[2+k], q_v1[2+k]);
      end
    end
    tests++;
    if (q_rden[4] !== 1'b0 || q_val[1] !== 1'b0 || q_val[5] !== 1'b0 || q_be[5] !== 8'h00 || q_addr[5] !== 32'h0) begin
      fails++; $display("FAIL basic_idle got rden4=%b val1=%b val5=%b be5=%h addr5=%h",
        q_rden[4], q_val[1], q_val[5], q_be[5], q_addr[5]);
    end
    tests++;
    if ({q_ready[1], q_ready[2], q_ready[3], q_ready[4], q_ready[5]} !== 5'b00001) begin
      fails++; $display("FAIL basic_ready got %b want 00001",
        {q_ready[1], q_ready[2], q_ready[3], q_ready[4], q_ready[5]});
    end
  endtask

  task automatic test_sew2();
    issue(11'd3, 2'd2, 9'h005, 32'h100, 32'h200, 32'h300, 0, 6);
    tests++;
    if (q_val[2] !== 1'b1 || q_be[2] !== 8'hFF || q_val[3] !== 1'b1 || q_be[3] !== 8'h0F || q_val[4] !== 1'b0) begin
      fails++; $display("FAIL sew2_be got v=%b%b%b be=%h,%h want 110 FF,0F",
        q_val[2], q_val[3], q_val[4], q_be[2], q_be[3]);
    end
    tests++;
    if (q_ready[3] !== 1'b0 || q_ready[4] !== 1'b1 || q_done[3] !== 1'b1 || q_addr[3] !== 32'h301) begin
      fails++; $display("FAIL sew2_timing got rdy3=%b rdy4=%b done3=%b addr3=%h",
        q_ready[3], q_ready[4], q_done[3], q_addr[3]);
    end
  endtask

  task automatic test_mask();
    logic [5:0] si_exp[3];
    logic [7:0] be_exp[3];
    si_exp[0] = 6'd0; si_exp[1] = 6'd8; si_exp[2] = 6'd16;
    be_exp[0] = 8'hFF; be_exp[1] = 8'hFF; be_exp[2] = 8'h0F;
    issue(11'd20, 2'd0, 9'h100, 32'h10, 32'h20, 32'h40, 0, 6);
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (q_val[2+k] !== 1'b1 || q_sidx[2+k] !== si_exp[k] || q_addr[2+k] !== 32'h40 || q_be[2+k] !== be_exp[k]) begin
        fails++; $display("FAIL mask k=%0d got v=%b idx=%0d addr=%h be=%h want idx=%0d addr=40 be=%h",
          k, q_val[2+k], q_sidx[2+k], q_addr[2+k], q_be[2+k], si_exp[k], be_exp[k]);
      end
    end
  endtask

  task automatic test_vl0();
    issue(11'd0, 2'd0, 9'h000, 32'h10, 32'h20, 32'h30, 0, 5);
    tests++;
    if (q_done[1] !== 1'b1 || q_ready[1] !== 1'b1 || q_err[1] !== 1'b0 || q_done[2] !== 1'b0) begin
      fails++; $display("FAIL vl0_done got done1=%b rdy1=%b err1=%b done2=%b",
        q_done[1], q_ready[1], q_err[1], q_done[2]);
    end
    tests++;
    if ({q_rden[1], q_rden[2], q_rden[3], q_val[1], q_val[2], q_val[3], q_val[4]} !== 7'b0) begin
      fails++; $display("FAIL vl0_quiet got %b want 0",
        {q_rden[1], q_rden[2], q_rden[3], q_val[1], q_val[2], q_val[3], q_val[4]});
    end
  endtask

  task automatic test_sew3();
    issue(11'd3, 2'd3, 9'h000, 32'h500, 32'h600, 32'h700, 0, 6);
    tests++;
    if (q_err[1] !== 1'b1 || q_done[1] !== 1'b0 || q_ready[1] !== 1'b1 || q_err[2] !== 1'b0) begin
      fails++; $display("FAIL sew3_err got err1=%b done1=%b rdy1=%b err2=%b",
        q_err[1], q_done[1], q_ready[1], q_err[2]);
    end
    tests++;
    if ({q_rden[1], q_rden[2], q_val[2], q_val[3], q_val[4]} !== 5'b0) begin
      fails++; $display("FAIL sew3_quiet got %b want 0", {q_rden[1], q_rden[2], q_val[2], q_val[3], q_val[4]});
    end
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (x_val[2+k] !== 1'b1 || x_be[2+k] !== 8'hFF || x_dn[2+k] !== (k == 2) || x_v0[2+k] !== {32'h0A0A0A0A, 32'h500 + k}) begin
        fails++; $display("FAIL sew3_en64 k=%0d got v=%b be=%h done=%b v0=%h",
          k, x_val[2+k], x_be[2+k], x_dn[2+k], x_v0[2+k]);
      end
    end
    tests++;
    if (x_val[5] !== 1'b0) begin
      fails++; $display("FAIL sew3_en64_end got v5=%b want 0", x_val[5]);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    instr_vl = 11'd20; instr_sew = 2'd0; instr_opSel = 9'h000;
    instr_vs1 = 32'h10; instr_vs2 = 32'h20; instr_vd = 32'h30; instr_valid = 1'b1;
    @(negedge clk); instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (alu_valid !== 1'b1 || alu_addr !== 32'h31) begin
      fails++; $display("FAIL rstmid_beat1 got v=%b addr=%h want 1 31", alu_valid, alu_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({instr_ready, rf_rd_en, alu_valid, done, err, alu_req_end} !== 6'b100000 ||
        {rf_rd_addr0, alu_addr, alu_be, alu_vec0} !== '0) begin
      fails++; $display("FAIL rstmid_clear got ctl=%b a0=%h addr=%h be=%h v0=%h",
        {instr_ready, rf_rd_en, alu_valid, done, err, alu_req_end}, rf_rd_addr0, alu_addr, alu_be, alu_vec0);
    end
    rst = 1'b0;
    issue(11'd20, 2'd0, 9'h000, 32'h50, 32'h60, 32'h70, 0, 6);
    tests++;
    if (q_rden[1] !== 1'b1 || q_a0[1] !== 32'h50 || q_val[2] !== 1'b1 || q_addr[2] !== 32'h70 || q_st[2] !== 1'b1) begin
      fails++; $display("FAIL rstmid_restart got en=%b a0=%h v=%b addr=%h st=%b",
        q_rden[1], q_a0[1], q_val[2], q_addr[2], q_st[2]);
    end
    tests++;
    if (q_be[4] !== 8'h0F || q_done[4] !== 1'b1 || q_en[4] !== 1'b1 || q_ready[5] !== 1'b1) begin
      fails++; $display("FAIL rstmid_end got be=%h done=%b end=%b rdy5=%b", q_be[4], q_done[4], q_en[4], q_ready[5]);
    end
  endtask

  initial begin
    test_reset();
    test_basic_busy();
    test_sew2();
    test_mask();
    test_vl0();
    test_sew3();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
